pwm_from_cnt: RTL and testbench



---
 rtl/pwm_from_cnt_pkg.sv | 12 +
 rtl/duty_shadow_reg.sv | 46 ++++
 rtl/pwm_from_cnt.sv | 83 ++++++++
 tb/tb_pwm_from_cnt.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pwm_from_cnt_pkg.sv
// rtl/pwm_from_cnt_pkg.sv - shared constants and state encoding for the counter-driven PWM
package pwm_from_cnt_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int DUTY_MAX  = 1 << CNT_W_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/duty_shadow_reg.sv
// rtl/duty_shadow_reg.sv - pending/active duty double buffer with valid/ready intake and boundary commit
module duty_shadow_reg #(
    parameter int CNT_W  = 4,
    parameter int DUTY_W = CNT_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              boundary,
    output logic              commit,
    output logic [DUTY_W-1:0] active_duty
);

    localparam logic [DUTY_W-1:0] SAT = DUTY_W'(2 ** CNT_W);

    logic [DUTY_W-1:0] pending_q;
    logic              pend_q;
    logic [DUTY_W-1:0] duty_sat;
    logic              accept;

    assign duty_sat = (duty_in > SAT) ? SAT : duty_in;
    assign accept   = duty_valid && duty_ready;
    // Only a value already pending when the boundary arrives is committed;
    // one accepted on the boundary cycle waits for the next wrap.
    assign commit   = boundary && pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            pend_q      <= 1'b0;
            duty_ready  <= 1'b1;
            active_duty <= '0;
        end else if (commit) begin
            active_duty <= pending_q;
            pend_q      <= 1'b0;
            duty_ready  <= 1'b1;
        end else if (accept) begin
            pending_q   <= duty_sat;
            pend_q      <= 1'b1;
            duty_ready  <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_from_cnt.sv
// rtl/pwm_from_cnt.sv - registered PWM from a wrap counter; PWM_INVERT_EN inverts output and idle level
module pwm_from_cnt
    import pwm_from_cnt_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DUTY_W = CNT_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              period_done,
    output logic [DUTY_W-1:0] active_duty
);

`ifdef PWM_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam logic             IDLE_LVL = INV;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [CNT_W-1:0] cnt_prev_q;
    logic             boundary;
    logic             commit;
    logic             pwm_d;

    // Edge-qualified so a counter stalled at max yields a single boundary.
    assign boundary = (cnt_in == CNT_MAX) && (cnt_prev_q != CNT_MAX);

    duty_shadow_reg #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .boundary    (boundary),
        .commit      (commit),
        .active_duty (active_duty)
    );

    always_comb begin
        state_d = state_q;
        pwm_d   = IDLE_LVL;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pwm_d = (DUTY_W'(cnt_in) < active_duty) ^ INV;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_prev_q  <= '0;
            period_done <= 1'b0;
            pwm_out     <= IDLE_LVL;
        end else begin
            state_q     <= state_d;
            cnt_prev_q  <= cnt_in;
            period_done <= boundary;
            pwm_out     <= pwm_d;
        end
    end

endmodule

// File: tb/tb_pwm_from_cnt.sv
// tb/tb_pwm_from_cnt.sv - directed self-checking bench for pwm_from_cnt (honours PWM_INVERT_EN)
module tb_pwm_from_cnt;

`ifdef PWM_INVERT_EN
    localparam int INV = 1;
`else
    localparam int INV = 0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;
    logic [4:0] active_duty;

    int tests_run;
    int tests_failed;
    int pd_count;

    pwm_from_cnt dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .active_duty (active_duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full counter period 0..15. d_exp < 0 means the FSM is still idle.
    // send_at < 0 means no duty handshake; rdy_mid < 0 skips the mid-period ready check.
    task automatic period(input int d_exp, input int send_at, input int send_val, input int rdy_mid);
        int exp_pwm;
        for (int c = 0; c < 16; c++) begin
            cnt_in = 4'(c);
            if (c == send_at) begin
                duty_in    = 5'(send_val);
                duty_valid = 1'b1;
            end
            cyc();
            duty_valid = 1'b0;
            if (d_exp < 0) exp_pwm = INV;
            else           exp_pwm = ((c < d_exp) ? 1 : 0) ^ INV;
            chk($sformatf("pwm d=%0d c=%0d", d_exp, c), 32'(pwm_out), 32'(exp_pwm));
            chk($sformatf("period_done c=%0d", c), 32'(period_done), (c == 15) ? 32'd1 : 32'd0);
            if (c == send_at) chk($sformatf("ready_after_accept c=%0d", c), 32'(duty_ready), 32'd0);
            if (c == 8 && rdy_mid >= 0) chk("ready_mid", 32'(duty_ready), 32'(rdy_mid));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cnt_in       = 4'd0;
        duty_in      = 5'd0;
        duty_valid   = 1'b0;
        cyc();
        cyc();
        chk("reset pwm", 32'(pwm_out), 32'(INV));
        chk("reset ready", 32'(duty_ready), 32'd1);
        chk("reset active", 32'(active_duty), 32'd0);
        chk("reset period_done", 32'(period_done), 32'd0);
        rst = 1'b0;

        // First commit of 5 at the first wrap; output idle throughout.
        period(-1, 0, 5, 0);
        chk("commit5 active", 32'(active_duty), 32'd5);
        chk("commit5 ready", 32'(duty_ready), 32'd1);

        // Running at 5, update to 12 mid-period.
        period(5, 6, 12, 0);
        chk("commit12 active", 32'(active_duty), 32'd12);
        chk("commit12 ready", 32'(duty_ready), 32'd1);

        // Accept 3 on the boundary cycle: not committed there.
        period(12, 15, 3, -1);
        chk("simul active", 32'(active_duty), 32'd12);
        chk("simul ready", 32'(duty_ready), 32'd0);

        period(12, -1, 0, 0);
        chk("commit3 active", 32'(active_duty), 32'd3);
        chk("commit3 ready", 32'(duty_ready), 32'd1);

        period(3, 0, 0, 0);
        chk("commit0 active", 32'(active_duty), 32'd0);

        period(0, 0, 16, 0);
        chk("commit16 active", 32'(active_duty), 32'd16);

        period(16, 0, 31, 0);
        chk("sat31 active", 32'(active_duty), 32'd16);

        period(16, -1, 0, 1);

        // Stalled counter at 15 for 5 cycles with a second update arriving mid-stall.
        cnt_in     = 4'd0;
        duty_in    = 5'd7;
        duty_valid = 1'b1;
        cyc();
        duty_valid = 1'b0;
        for (int c = 1; c < 15; c++) begin
            cnt_in = 4'(c);
            cyc();
        end
        pd_count = 0;
        cnt_in   = 4'd15;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                duty_in    = 5'd9;
                duty_valid = 1'b1;
            end
            cyc();
            duty_valid = 1'b0;
            if (period_done === 1'b1) pd_count++;
            chk($sformatf("stall active k=%0d", k), 32'(active_duty), 32'd7);
        end
        cyc();
        if (period_done === 1'b1) pd_count++;
        chk("stall period_done count", 32'(pd_count), 32'd1);
        chk("stall pending ready", 32'(duty_ready), 32'd0);

        // Asynchronous reset mid-period with duty 9 pending.
        for (int c = 0; c < 8; c++) begin
            cnt_in = 4'(c);
            cyc();
        end
        rst = 1'b1;
        #1;
        chk("async rst pwm", 32'(pwm_out), 32'(INV));
        chk("async rst ready", 32'(duty_ready), 32'd1);
        chk("async rst active", 32'(active_duty), 32'd0);
        chk("async rst period_done", 32'(period_done), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        // Pending value discarded: no commit without a new handshake.
        period(-1, -1, 0, 1);
        chk("post rst active", 32'(active_duty), 32'd0);
        chk("post rst ready", 32'(duty_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
